// File: rtl/cosim_vec_driver.sv
// Co-simulation vector driver: drives one stimulus vector into a DUT, waits SETTLE
// cycles, checks that the DUT echoed it unchanged, and reports the per-bit difference.
module cosim_vec_driver #(
    parameter int WIDTH  = 128,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic [WIDTH-1:0] drv,
    input  logic [WIDTH-1:0] obs,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             r_mismatch,
    output logic [WIDTH-1:0] r_diff,
    output logic [15:0]      err_count,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, DRIVE, REPORT} state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   drv_q, drv_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               mis_q, mis_d;
    logic [15:0]        err_q, err_d;
    logic [WIDTH-1:0]   obs_x;

    assign obs_x = obs ^ drv_q;

    always_comb begin
        state_d = state_q;
        drv_d   = drv_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        mis_d   = mis_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    drv_d   = s_data;
                    cnt_d   = 4'd0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // obs is only looked at on the final settle edge
                if (cnt_q == LAST) begin
                    diff_d  = obs_x;
                    mis_d   = |obs_x;
                    if (|obs_x && err_q != 16'hFFFF)
                        err_d = err_q + 16'd1;
                    state_d = REPORT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            REPORT: begin
                if (r_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drv_q   <= '0;
            cnt_q   <= 4'd0;
            diff_q  <= '0;
            mis_q   <= 1'b0;
            err_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            drv_q   <= drv_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign s_ready    = (state_q == IDLE);
    assign r_valid    = (state_q == REPORT);
    assign busy       = (state_q != IDLE);
    assign drv        = drv_q;
    assign r_diff     = diff_q;
    assign r_mismatch = mis_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_cosim_vec_driver.sv
// Randomized scoreboard bench for cosim_vec_driver (SETTLE=2, WIDTH=128) plus a
// directed SETTLE=1 instance.
module tb_cosim_vec_driver;

    localparam int SA = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A: WIDTH=128, SETTLE=2; obs = drv ^ fault_a
    logic         a_svalid, a_sready, a_rvalid, a_rready, a_mis, a_busy;
    logic [127:0] a_sdata, a_drv, a_obs, a_diff, fault_a;
    logic [15:0]  a_err;
    assign a_obs = a_drv ^ fault_a;

    cosim_vec_driver #(.WIDTH(128), .SETTLE(SA)) dut_a (
        .clk(clk), .rst(rst), .s_valid(a_svalid), .s_ready(a_sready), .s_data(a_sdata),
        .drv(a_drv), .obs(a_obs), .r_valid(a_rvalid), .r_ready(a_rready),
        .r_mismatch(a_mis), .r_diff(a_diff), .err_count(a_err), .busy(a_busy));

    // instance B: WIDTH=8, SETTLE=1; obs driven directly
    logic       b_svalid, b_sready, b_rvalid, b_rready, b_mis, b_busy;
    logic [7:0] b_sdata, b_drv, b_obs, b_diff;
    logic [15:0] b_err;

    cosim_vec_driver #(.WIDTH(8), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .s_valid(b_svalid), .s_ready(b_sready), .s_data(b_sdata),
        .drv(b_drv), .obs(b_obs), .r_valid(b_rvalid), .r_ready(b_rready),
        .r_mismatch(b_mis), .r_diff(b_diff), .err_count(b_err), .busy(b_busy));

    typedef struct {
        logic         mis;
        logic [127:0] diff;
        logic [15:0]  err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   err_model = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // monitor: compare each presented result against the oldest expectation
    always @(negedge clk) begin
        if (!rst && a_rvalid && a_rready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("r_mismatch", {127'd0, a_mis}, {127'd0, e.mis});
                chk("r_diff", a_diff, e.diff);
                chk("err_count", {112'd0, a_err}, {112'd0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One vector through A. fault_s is the obs error present at the sampling edge;
    // when noisy, obs carries garbage on every other edge.
    task automatic send_a(input logic [127:0] data, input logic [127:0] fault_s,
                          input bit noisy, input int bp);
        int   guard;
        exp_t e;
        guard = 0;
        while (!a_sready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) chk("wait_s_ready_timeout", 128'd0, 128'd1);
        fault_a  = noisy ? rnd128() : fault_s;
        a_sdata  = data;
        a_svalid = 1'b1;
        a_rready = 1'b0;
        tick();                       // handshake edge k
        a_svalid = 1'b0;
        a_sdata  = rnd128();
        chk("drv_after_hs", a_drv, data);
        for (int i = 1; i <= SA; i++) begin
            fault_a = (i == SA) ? fault_s : (noisy ? rnd128() : fault_s);
            chk("r_valid_early", {127'd0, a_rvalid}, 128'd0);
            tick();
        end
        chk("r_valid_latency", {127'd0, a_rvalid}, 128'd1);
        e.mis  = (fault_s != 128'd0);
        e.diff = fault_s;
        if (e.mis && err_model < 65535) err_model++;
        e.err  = 16'(err_model);
        sb.push_back(e);
        for (int i = 0; i < bp; i++) begin
            fault_a  = rnd128();
            a_svalid = $urandom_range(0, 1) == 1;
            a_sdata  = rnd128();
            tick();
            chk("bp_r_valid", {127'd0, a_rvalid}, 128'd1);
            chk("bp_s_ready", {127'd0, a_sready}, 128'd0);
            chk("bp_r_diff", a_diff, fault_s);
            chk("bp_r_mismatch", {127'd0, a_mis}, {127'd0, e.mis});
            chk("bp_drv_hold", a_drv, data);
        end
        a_svalid = 1'b0;
        a_rready = 1'b1;
        tick();                       // result handshake
        a_rready = 1'b0;
        chk("s_ready_after_result", {127'd0, a_sready}, 128'd1);
        chk("r_valid_after_result", {127'd0, a_rvalid}, 128'd0);
        chk("drv_hold_idle", a_drv, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] f;
        rst = 1'b1;
        a_svalid = 0; a_rready = 0; a_sdata = '0; fault_a = '0;
        b_svalid = 0; b_rready = 0; b_sdata = '0; b_obs = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_s_ready", {127'd0, a_sready}, 128'd1);
        chk("rst_r_valid", {127'd0, a_rvalid}, 128'd0);
        chk("rst_busy", {127'd0, a_busy}, 128'd0);
        chk("rst_drv", a_drv, 128'd0);
        chk("rst_diff", a_diff, 128'd0);
        chk("rst_err", {112'd0, a_err}, 128'd0);

        // pass-through and single-bit fault
        send_a(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'd0, 1'b0, 0);
        send_a(128'h1, 128'h1, 1'b0, 0);
        // backpressure with garbage s_valid pulses
        send_a(rnd128(), 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 5);

        // reset in the first DRIVE cycle with a faulting obs
        fault_a  = rnd128() | 128'h1;
        a_sdata  = rnd128();
        a_svalid = 1'b1;
        tick();
        a_svalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        err_model = 0;
        chk("mid_rst_s_ready", {127'd0, a_sready}, 128'd1);
        chk("mid_rst_r_valid", {127'd0, a_rvalid}, 128'd0);
        chk("mid_rst_busy", {127'd0, a_busy}, 128'd0);
        chk("mid_rst_mis", {127'd0, a_mis}, 128'd0);
        chk("mid_rst_diff", a_diff, 128'd0);
        chk("mid_rst_drv", a_drv, 128'd0);
        chk("mid_rst_err", {112'd0, a_err}, 128'd0);
        tick();
        chk("mid_rst_err_hold", {112'd0, a_err}, 128'd0);

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0: f = 128'd0;
                1: f = 128'd1 << $urandom_range(0, 127);
                default: f = rnd128();
            endcase
            send_a(rnd128(), f, 1'b1, $urandom_range(0, 3));
        end

        // saturation: preload 0xFFFE, then three mismatches
        @(negedge clk);
        force dut_a.err_q = 16'hFFFE;
        tick();
        release dut_a.err_q;
        err_model = 16'hFFFE;
        chk("preload_err", {112'd0, a_err}, 128'hFFFE);
        send_a(rnd128(), 128'h10, 1'b0, 0);
        send_a(rnd128(), 128'h20, 1'b1, 0);
        send_a(rnd128(), 128'h30, 1'b0, 0);
        send_a(rnd128(), 128'h0, 1'b0, 0);
        chk("sat_hold", {112'd0, a_err}, 128'hFFFF);

        // SETTLE=1: obs changes only after the sampling edge
        b_sdata  = 8'hA5;
        b_svalid = 1'b1;
        tick();                       // handshake edge k
        b_svalid = 1'b0;
        b_sdata  = 8'h00;
        b_obs    = 8'hA5 ^ 8'h3C;     // present at sampling edge k+1
        chk("b_drv", {120'd0, b_drv}, {120'd0, 8'hA5});
        tick();
        b_obs = 8'hFF;
        chk("b_r_valid_lat", {127'd0, b_rvalid}, 128'd1);
        chk("b_diff", {120'd0, b_diff}, {120'd0, 8'h3C});
        chk("b_mis", {127'd0, b_mis}, 128'd1);
        chk("b_err", {112'd0, b_err}, 128'd1);
        tick();
        chk("b_diff_hold", {120'd0, b_diff}, {120'd0, 8'h3C});
        b_rready = 1'b1;
        tick();
        b_rready = 1'b0;
        chk("b_s_ready", {127'd0, b_sready}, 128'd1);
        b_sdata  = 8'h5A;
        b_svalid = 1'b1;
        tick();
        b_svalid = 1'b0;
        b_obs    = 8'h5A;
        tick();
        b_obs = 8'h00;
        chk("b_pass_valid", {127'd0, b_rvalid}, 128'd1);
        chk("b_pass_mis", {127'd0, b_mis}, 128'd0);
        chk("b_pass_diff", {120'd0, b_diff}, 128'd0);
        chk("b_pass_err", {112'd0, b_err}, 128'd1);

        tick();
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cosim_vec_driver.md
COSIM_VEC_DRIVER -- requirements
Module: cosim_vec_driver

Interface
REQ-001 Parameter: WIDTH, default 128, bit width of stimulus/observed vectors.
REQ-002 Parameter: SETTLE, default 2, cycles a vector is held on drv before obs is sampled; legal range 1..15.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: s_valid  input  1  stimulus vector offered.
REQ-006 Port: s_ready  output  1  driver can accept a stimulus vector.
REQ-007 Port: s_data  input  WIDTH  stimulus vector.
REQ-008 Port: drv  output  WIDTH  vector driven into the DUT's "in" port.
REQ-009 Port: obs  input  WIDTH  DUT's "out" port, sampled as the response.
REQ-010 Port: r_valid  output  1  check result available.
REQ-011 Port: r_ready  input  1  consumer accepts check result.
REQ-012 Port: r_mismatch  output  1  1 when sampled obs differed from drv.
REQ-013 Port: r_diff  output  WIDTH  bitwise obs XOR drv at sample time.
REQ-014 Port: err_count  output  16  saturating count of mismatched checks since reset.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, DRIVE, REPORT; encoding is free.
REQ-017 s_ready SHALL be 1 only in IDLE; r_valid SHALL be 1 only in REPORT.
REQ-018 Stimulus handshake = s_valid & s_ready at a rising edge; on it, drv <= s_data, settle counter <= 0, state <= DRIVE.
REQ-019 In DRIVE, counter increments each edge; on the edge where counter == SETTLE-1, obs is sampled: r_diff <= obs ^ drv, r_mismatch <= |(obs ^ drv), state <= REPORT.
REQ-020 Latency: handshake at edge k -> drv updated after edge k -> r_valid high after edge k+SETTLE.
REQ-021 Expected response is identity (obs must equal drv bit-for-bit); no other transform.
REQ-022 err_count SHALL increment by 1 on the sampling edge when the mismatch is 1, and hold at 16'hFFFF once reached.
REQ-023 In REPORT, r_valid, r_mismatch, r_diff SHALL hold stable until r_valid & r_ready at an edge, then state <= IDLE.
REQ-024 No back-to-back bypass: s_ready rises only in the cycle after the result handshake.
REQ-025 drv SHALL hold the last accepted vector through DRIVE, REPORT and subsequent IDLE until the next stimulus handshake.
REQ-026 s_data and s_valid SHALL be ignored outside IDLE; r_ready SHALL be ignored outside REPORT.
REQ-027 obs SHALL be ignored on all edges except the sampling edge.

Reset
REQ-028 When rst is 1 at an edge: state <= IDLE, drv <= 0, counter <= 0, r_diff <= 0, r_mismatch <= 0, err_count <= 0.
REQ-029 Reset values after rst: s_ready=1, r_valid=0, busy=0, r_mismatch=0, r_diff=0, drv=0, err_count=0.
REQ-030 rst SHALL take priority over all handshakes; reset mid-DRIVE or mid-REPORT discards the in-flight vector and result, with no err_count update.

Verification
REQ-031 Pass-through: obs tied to drv, SETTLE=2; s_data=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> r_valid 2 cycles after handshake, r_mismatch=0, r_diff=0, err_count=0.
REQ-032 Bit-0 fault: obs = drv with bit 0 inverted; s_data=128'h1 -> r_mismatch=1, r_diff=128'h1, err_count=1.
REQ-033 Backpressure: r_ready held 0 for 5 cycles in REPORT -> r_valid, r_diff, r_mismatch stable; s_ready=0; s_valid pulses ignored; after r_ready=1, s_ready=1 on the next cycle.
REQ-034 Reset mid-operation: rst asserted in the first DRIVE cycle with a faulting obs -> all outputs at reset values next cycle; err_count stays 0.
REQ-035 Saturation: preload 65535 mismatched checks (or force err_count=16'hFFFE, then two mismatches) -> err_count=16'hFFFF and holds.
REQ-036 SETTLE=1 build: obs changes only in the cycle after the sampling edge -> the result reflects the value sampled at the sampling edge; r_valid 1 cycle after handshake.
